// File: rtl/flex_down_timer.sv
// Parameterised down-counting timer with one-shot / auto-reload modes and a
// registered terminal-count pulse. Companion to the flex up-counter.
module flex_down_timer #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    count_enable,
  input  logic                    periodic,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    expire_flag,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    mode_q, mode_d;
  logic                    flag_q, flag_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    flag_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      // A restart discards any terminal count landing in the same cycle.
      reload_d = load_val;
      mode_d   = periodic;
      cnt_d    = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && count_enable) begin
      // Terminal check precedes decrement, so the count never wraps.
      if (cnt_q <= NUM_CNT_BITS'(1)) begin
        flag_d = 1'b1;
        if (mode_q) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end else begin
        cnt_d = cnt_q - NUM_CNT_BITS'(1);
      end
    end
  end

  assign count_out   = cnt_q;
  assign expire_flag = flag_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_flex_down_timer.sv
// Directed self-checking bench for flex_down_timer: one-shot, periodic,
// gapped enable, priority, boundary values and async reset.
module tb_flex_down_timer;
  logic       clk = 1'b0;
  logic       n_rst, clear, load, count_enable, periodic;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic       expire_flag, busy, done;

  int checks = 0;
  int errors = 0;
  int pulses;

  flex_down_timer #(.NUM_CNT_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
    .count_enable(count_enable), .periodic(periodic), .load_val(load_val),
    .count_out(count_out), .expire_flag(expire_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input int f, input int b, input int d);
    check({tag, ".count"}, 32'(count_out), 32'(c));
    check({tag, ".flag"},  32'(expire_flag), 32'(f));
    check({tag, ".busy"},  32'(busy), 32'(b));
    check({tag, ".done"},  32'(done), 32'(d));
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; load = 1'b0; count_enable = 1'b0;
    periodic = 1'b0; load_val = 4'd0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    n_rst = 1'b1;
    step();
    chk_all("idle", 0, 0, 0, 0);

    // One-shot 3
    load = 1'b1; load_val = 4'd3; periodic = 1'b0; count_enable = 1'b1;
    step(); load = 1'b0;
    chk_all("os.load", 3, 0, 1, 0);
    step(); chk_all("os.2", 2, 0, 1, 0);
    step(); chk_all("os.1", 1, 0, 1, 0);
    step(); chk_all("os.term", 0, 1, 0, 1);
    step(); chk_all("os.hold", 0, 0, 0, 1);
    step(); chk_all("os.hold2", 0, 0, 0, 1);

    // Periodic 4, 12 enabled cycles
    load = 1'b1; load_val = 4'd4; periodic = 1'b1;
    step(); load = 1'b0;
    chk_all("per.load", 4, 0, 1, 0);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (expire_flag) pulses++;
      chk_all("per.run", (k % 4 == 0) ? 4 : 4 - (k % 4), (k % 4 == 0) ? 1 : 0, 1, 0);
    end
    check("per.pulses", 32'(pulses), 32'd3);

    // Gapped enable, one-shot 2
    load = 1'b1; load_val = 4'd2; periodic = 1'b0; count_enable = 1'b0;
    step(); load = 1'b0;
    chk_all("gap.load", 2, 0, 1, 0);
    count_enable = 1'b1; step(); chk_all("gap.e1", 1, 0, 1, 0);
    count_enable = 1'b0; step(); chk_all("gap.g1", 1, 0, 1, 0);
    step(); chk_all("gap.g2", 1, 0, 1, 0);
    count_enable = 1'b1; step(); chk_all("gap.e2", 0, 1, 0, 1);
    count_enable = 1'b0; step(); chk_all("gap.after", 0, 0, 0, 1);

    // clear beats load in RUN
    load = 1'b1; load_val = 4'd7;
    step(); load = 1'b0;
    count_enable = 1'b1; step(); chk_all("pri.run", 6, 0, 1, 0);
    clear = 1'b1; load = 1'b1; load_val = 4'd9;
    step(); clear = 1'b0; load = 1'b0;
    chk_all("pri.clear", 0, 0, 0, 0);
    step(); chk_all("pri.idle", 0, 0, 0, 0);

    // load on terminal cycle discards the flag
    count_enable = 1'b0; load = 1'b1; load_val = 4'd2;
    step(); load = 1'b0;
    count_enable = 1'b1; step(); chk_all("pri.pre", 1, 0, 1, 0);
    load = 1'b1; load_val = 4'd5;
    step(); load = 1'b0;
    chk_all("pri.reload", 5, 0, 1, 0);
    step(); chk_all("pri.cont", 4, 0, 1, 0);

    // load_val = 0 goes IDLE with no flag
    load = 1'b1; load_val = 4'd0;
    step(); load = 1'b0;
    chk_all("zero.load", 0, 0, 0, 0);
    step(); chk_all("zero.idle", 0, 0, 0, 0);

    // Periodic reload of 1: flag continuously high
    load = 1'b1; load_val = 4'd1; periodic = 1'b1;
    step(); load = 1'b0;
    chk_all("one.load", 1, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(); chk_all("one.run", 1, 1, 1, 0);
    end

    // Full-scale 15, one-shot
    load = 1'b1; load_val = 4'd15; periodic = 1'b0;
    step(); load = 1'b0;
    chk_all("max.load", 15, 0, 1, 0);
    for (int k = 1; k <= 14; k++) begin
      step(); chk_all("max.run", 15 - k, 0, 1, 0);
    end
    step(); chk_all("max.term", 0, 1, 0, 1);

    // Async reset mid-RUN
    load = 1'b1; load_val = 4'd7;
    step(); load = 1'b0;
    step(); chk_all("ar.run", 6, 0, 1, 0);
    #2 n_rst = 1'b0;
    #1 chk_all("ar.assert", 0, 0, 0, 0);
    #1 n_rst = 1'b1;
    step(); chk_all("ar.post1", 0, 0, 0, 0);
    step(); chk_all("ar.post2", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flex_down_timer.md
Name: flex_down_timer

Overview:
- Parameterised down-counting timer; the count-down counterpart of the team's flex up-counter.
- Loads a start value, decrements on each enabled cycle, and pulses a terminal-count flag when it expires.
- Runs in one-shot or periodic (auto-reload) mode.
- Used by receiver/transmitter FSMs for bit-period, timeout and inter-packet-gap timing.

Parameters:
- NUM_CNT_BITS, 4, width of the count, load value and reload register.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort: return to IDLE, count zeroed.
- load  input  1  synchronous start/restart with load_val.
- count_enable  input  1  decrement qualifier (tick strobe).
- periodic  input  1  sampled at load: 1 = auto-reload, 0 = one-shot.
- load_val  input  NUM_CNT_BITS  start/reload value, unsigned.
- count_out  output  NUM_CNT_BITS  current remaining count, registered.
- expire_flag  output  1  registered terminal-count pulse.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot expired, awaiting load/clear).

Behaviour:
- Reset (n_rst=0, async):
  - count_out=0, expire_flag=0, reload register=0, mode bit=0, state=IDLE.
  - busy=0, done=0.
- States: IDLE, RUN, DONE. busy and done decode combinationally from the state register only.
- Synchronous priority, highest first: clear > load > count_enable.
- clear, any state:
  - count_out<=0, expire_flag<=0, state<=IDLE.
  - Reload register and mode bit are unchanged.
- load, any state, clear low:
  - reload<=load_val, mode<=periodic, count_out<=load_val, expire_flag<=0.
  - If load_val!=0: state<=RUN.
  - If load_val==0: state<=IDLE, no flag ever produced.
  - load in RUN restarts the count; a terminal count in that same cycle is discarded, so no flag.
- RUN, count_enable=1, no clear/load:
  - count_out>1: count_out<=count_out-1, expire_flag<=0.
  - count_out==1 (terminal): expire_flag<=1.
    - Periodic: count_out<=reload, stay RUN.
    - One-shot: count_out<=0, state<=DONE.
- RUN, count_enable=0: count_out holds, expire_flag<=0.
- Flag timing:
  - expire_flag is high for exactly the one cycle following the terminal edge.
  - Periodic with reload==1 and count_enable held high: terminal every cycle, so expire_flag stays high continuously.
- IDLE and DONE:
  - count_enable is ignored; count_out holds (0 in DONE); expire_flag<=0.
- Arithmetic:
  - Unsigned; decrement never wraps below 1 in RUN (terminal handling precedes decrement).
  - load_val = all-ones (2^N-1) is legal and gives 2^N-1 enabled cycles per period.
- Period: N enabled cycles from load to the flag for load_val=N, counting the enabled cycles only.
- Inputs are assumed synchronous to clk. A mid-operation reset returns to the reset state immediately, regardless of state.

Test Plan:
- Reset then one-shot: load_val=3, periodic=0, load 1 cycle, count_enable held 1 -> count_out 3,2,1,0; expire_flag high 1 cycle when count_out becomes 0; done=1, busy=0; count_out stays 0.
- Periodic: load_val=4, periodic=1, enable held 1 for 12 cycles -> count_out 4,3,2,1,4,3,2,1,...; expire_flag pulses each time count_out returns to 4, 3 pulses total; busy stays 1.
- Gapped enable: load_val=2, one-shot, count_enable 1,0,0,1 -> count_out 2,1,1,1,0; flag only after the 2nd enabled cycle; flag low during enable gaps.
- Priority: clear and load asserted together in RUN -> IDLE, count_out=0. In a later run, load (load_val=5) asserted on the terminal cycle -> count_out=5, expire_flag stays 0, busy=1.
- Boundaries: load_val=0 -> IDLE, no flag. Periodic load_val=1 with enable held -> expire_flag continuously high, count_out=1. load_val=15 (N=4) -> flag after exactly 15 enabled cycles.
- Async reset asserted mid-RUN (count_out=6) -> count_out=0, expire_flag=0, busy=0, done=0 immediately; count_enable ignored after release until the next load.
